load_store_unit: RTL and testbench

- Sits between the execute stage and the byte-addressed data memory.
- Accepts load/store micro-ops through a valid/ready handshake.
- Converts them into the memory's edge-triggered request pulses: a one-cycle high pulse, then low.
- Buffers stores in a small in-order queue. Extracts and sign/zero-extends load data and returns it with the destination tag.

---
 rtl/lsu_pkg.sv | 42 ++++
 rtl/lsu_store_fifo.sv | 49 ++++
 rtl/load_store_unit.sv | 148 ++++++++++++++
 tb/tb_load_store_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings, state enums and load-extension helper for the load/store unit
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [2:0] WT_SB = 3'b000;
    localparam logic [2:0] WT_SH = 3'b001;
    localparam logic [2:0] WT_SW = 3'b010;

    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_LOW} sstate_t;
    typedef enum logic [1:0] {L_IDLE, L_REQ, L_WAIT, L_RESP} lstate_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  wtype;
    } sb_entry_t;

    function automatic logic store_legal(input logic [2:0] f);
        return f inside {WT_SB, WT_SH, WT_SW};
    endfunction

    function automatic logic load_legal(input logic [2:0] f);
        return f inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

    // memory already aligns byte a into [7:0], so only extension is needed
    function automatic logic [31:0] load_extend(input logic [2:0] f, input logic [31:0] d);
        case (f)
            F3_B:    return {{24{d[7]}}, d[7:0]};
            F3_BU:   return {24'b0, d[7:0]};
            F3_H:    return {{16{d[15]}}, d[15:0]};
            F3_HU:   return {16'b0, d[15:0]};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/lsu_store_fifo.sv
// lsu_store_fifo: in-order synchronous store buffer with push/pop/full/empty/count
module lsu_store_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 67
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = count == (AW + 1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // storage is not reset; only pointers and count define validity
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: turns load/store micro-ops into one-cycle memory request pulses
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int SB_DEPTH = 4,
    parameter int MEM_LAT  = 1,
    parameter int TAG_W    = 5
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_is_store,
    input  logic [2:0]       req_funct3,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             illegal_op,
    output logic             mem_load_req,
    output logic [31:0]      mem_load_addr,
    input  logic [31:0]      mem_load_data,
    output logic             mem_write_req,
    output logic [31:0]      mem_write_addr,
    output logic [31:0]      mem_write_data,
    output logic [2:0]       mem_write_type
);

    localparam int CNT_W = $clog2(SB_DEPTH) + 1;
    localparam int CW    = $clog2(MEM_LAT + 1);

    sstate_t          sstate, s_next;
    lstate_t          lstate, l_next;
    sb_entry_t        head;
    logic [CNT_W-1:0] sb_count;
    logic             sb_full, sb_empty;
    logic             fire, is_illegal, push, pop;
    logic [2:0]       ld_f3;
    logic [CW-1:0]    cnt;

    // loads wait for an idle unit with a drained buffer so they never pass older stores
    assign req_ready  = rst_n && (req_is_store ? !sb_full
                                               : (lstate == L_IDLE && sb_empty && sstate == S_IDLE));
    assign fire       = req_valid && req_ready;
    assign is_illegal = req_is_store ? !store_legal(req_funct3) : !load_legal(req_funct3);
    assign push       = fire && req_is_store && !is_illegal;
    assign pop        = sstate == S_LOW;

    lsu_store_fifo #(
        .DEPTH (SB_DEPTH),
        .W     ($bits(sb_entry_t))
    ) u_fifo (
        .clock (clock),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   ({req_addr, req_wdata, req_funct3}),
        .dout  (head),
        .full  (sb_full),
        .empty (sb_empty),
        .count (sb_count)
    );

    // drain FSM: pulse then low per entry; head stays put until popped at the end of S_LOW
    always_comb begin
        s_next         = sstate;
        mem_write_req  = 1'b0;
        mem_write_addr = '0;
        mem_write_data = '0;
        mem_write_type = '0;
        case (sstate)
            S_IDLE:  if (!sb_empty) s_next = S_PULSE;
            S_PULSE: begin
                s_next         = S_LOW;
                mem_write_req  = 1'b1;
                mem_write_addr = head.addr;
                mem_write_data = head.data;
                mem_write_type = head.wtype;
            end
            S_LOW: begin
                s_next         = (sb_count > CNT_W'(1) || push) ? S_PULSE : S_IDLE;
                mem_write_addr = head.addr;
                mem_write_data = head.data;
                mem_write_type = head.wtype;
            end
            default: s_next = S_IDLE;
        endcase
    end

    // store FSM state and the registered illegal-op pulse
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            sstate     <= S_IDLE;
            illegal_op <= 1'b0;
        end else begin
            sstate     <= s_next;
            illegal_op <= fire && is_illegal;
        end
    end

    // load FSM next state and request/response strobes
    always_comb begin
        l_next       = lstate;
        mem_load_req = 1'b0;
        resp_valid   = 1'b0;
        case (lstate)
            L_IDLE: if (fire && !req_is_store && !is_illegal) l_next = L_REQ;
            L_REQ: begin
                l_next       = L_WAIT;
                mem_load_req = 1'b1;
            end
            L_WAIT: if (cnt == CW'(1)) l_next = L_RESP;
            L_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) l_next = L_IDLE;
            end
            default: l_next = L_IDLE;
        endcase
    end

    // load datapath: latch op on accept, count memory latency, capture extended data
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            lstate        <= L_IDLE;
            cnt           <= '0;
            mem_load_addr <= '0;
            ld_f3         <= '0;
            resp_tag      <= '0;
            resp_data     <= '0;
        end else begin
            lstate <= l_next;
            if (lstate == L_IDLE && l_next == L_REQ) begin
                mem_load_addr <= req_addr;
                ld_f3         <= req_funct3;
                resp_tag      <= req_tag;
            end
            if (lstate == L_REQ) cnt <= CW'(MEM_LAT);
            if (lstate == L_WAIT) begin
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) resp_data <= load_extend(ld_f3, mem_load_data);
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench with a byte-addressed memory model
module tb_load_store_unit;

    localparam int LAT = 2;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_tag;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_tag;
    logic        illegal_op;
    logic        mem_load_req;
    logic [31:0] mem_load_addr, mem_load_data;
    logic        mem_write_req;
    logic [31:0] mem_write_addr, mem_write_data;
    logic [2:0]  mem_write_type;

    int checks = 0;
    int failures = 0;

    load_store_unit #(.SB_DEPTH(4), .MEM_LAT(LAT), .TAG_W(5)) dut (
        .clock          (clock),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_is_store   (req_is_store),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_tag        (req_tag),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .resp_tag       (resp_tag),
        .illegal_op     (illegal_op),
        .mem_load_req   (mem_load_req),
        .mem_load_addr  (mem_load_addr),
        .mem_load_data  (mem_load_data),
        .mem_write_req  (mem_write_req),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data),
        .mem_write_type (mem_write_type)
    );

    always #5 clock = ~clock;

    logic [7:0]  mem [0:65535];
    logic [15:0] la, wa;
    logic [31:0] wr_addr_log [32];
    logic [31:0] wr_data_log [32];
    int          wr_cyc_log [32];
    int          wr_n = 0, ld_n = 0, resp_cnt = 0, cyc = 0;

    assign la = mem_load_addr[15:0];
    assign wa = mem_write_addr[15:0];

    // memory model: preload on reset, capture loads on the pulse, apply and log writes
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            mem[16'h1000] <= 8'h80;
            mem[16'h1001] <= 8'h7F;
            mem[16'h1002] <= 8'h01;
            mem[16'h1003] <= 8'hFF;
        end
        if (resp_valid && resp_ready) resp_cnt <= resp_cnt + 1;
        if (mem_load_req) begin
            ld_n          <= ld_n + 1;
            mem_load_data <= {mem[la + 16'd3], mem[la + 16'd2], mem[la + 16'd1], mem[la]};
        end
        if (mem_write_req) begin
            mem[wa] <= mem_write_data[7:0];
            if (mem_write_type != 3'b000) mem[wa + 16'd1] <= mem_write_data[15:8];
            if (mem_write_type == 3'b010) begin
                mem[wa + 16'd2] <= mem_write_data[23:16];
                mem[wa + 16'd3] <= mem_write_data[31:24];
            end
            if (wr_n < 32) begin
                wr_addr_log[wr_n] <= mem_write_addr;
                wr_data_log[wr_n] <= mem_write_data;
                wr_cyc_log[wr_n]  <= cyc;
            end
            wr_n <= wr_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // present an op at a negedge, wait for ready, return one negedge after acceptance
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] tg, output int waited);
        req_valid    = 1'b1;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = a;
        req_wdata    = d;
        req_tag      = tg;
        #1;
        waited = 0;
        while (!req_ready && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        chk("issue_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int n);
        n = 1;
        while (!resp_valid && n < 40) begin
            @(negedge clock);
            n++;
        end
    endtask

    logic [2:0]  t1_f3  [5];
    logic [31:0] t1_exp [5];
    int w, n, snap_w, snap_l, snap_r;
    int sw [6];

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_is_store = 1'b0;
        req_funct3 = '0;
        req_addr = '0;
        req_wdata = '0;
        req_tag = '0;
        resp_ready = 1'b1;
        t1_f3  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        t1_exp = '{32'hFFFFFF80, 32'h00000080, 32'h00007F80, 32'h00007F80, 32'hFF017F80};
        repeat (3) @(negedge clock);
        chk("rst_ctrl", {27'b0, req_ready, mem_load_req, mem_write_req, resp_valid, illegal_op}, 32'd0);
        rst_n = 1'b1;
        @(negedge clock);
        chk("idle_load_ready", {31'b0, req_ready}, 32'd1);

        // extension variants from one word
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, t1_f3[i], 32'h1000, 32'h0, 5'(i + 1), w);
            wait_resp(n);
            chk("t1_latency", n, LAT + 2);
            chk("t1_data", resp_data, t1_exp[i]);
            chk("t1_tag", {27'b0, resp_tag}, i + 1);
        end

        // load behind a buffered store stalls until the store drains
        snap_w = wr_n;
        issue(1'b1, 3'b010, 32'h2001, 32'hDEADBEEF, 5'd0, w);
        issue(1'b0, 3'b010, 32'h2001, 32'h0, 5'd7, w);
        chk("t2_stall_cycles", w, 3);
        wait_resp(n);
        chk("t2_latency", n, LAT + 2);
        chk("t2_data", resp_data, 32'hDEADBEEF);
        chk("t2_tag", {27'b0, resp_tag}, 32'd7);
        chk("t2_write_pulses", wr_n - snap_w, 1);

        // six back-to-back stores: buffer fills as drain runs at half rate, sixth stalls once
        @(negedge clock);
        snap_w = wr_n;
        for (int i = 0; i < 6; i++) issue(1'b1, 3'b010, 32'h3000 + 32'(4 * i), 32'h11110000 + 32'(i), 5'd0, sw[i]);
        for (int i = 0; i < 6; i++) chk("t3_stall", sw[i], (i == 5) ? 1 : 0);
        n = 0;
        while (wr_n - snap_w < 6 && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("t3_pulse_count", wr_n - snap_w, 6);
        for (int i = 0; i < 6; i++) begin
            chk("t3_addr", wr_addr_log[snap_w + i], 32'h3000 + 32'(4 * i));
            chk("t3_data", wr_data_log[snap_w + i], 32'h11110000 + 32'(i));
            if (i > 0) chk("t3_spacing", wr_cyc_log[snap_w + i] - wr_cyc_log[snap_w + i - 1], 2);
        end
        repeat (3) @(negedge clock);

        // response back-pressure keeps the result stable and issues no new request
        resp_ready = 1'b0;
        snap_l = ld_n;
        issue(1'b0, 3'b101, 32'h1000, 32'h0, 5'd9, w);
        wait_resp(n);
        chk("t4_latency", n, LAT + 2);
        repeat (10) begin
            chk("t4_valid", {31'b0, resp_valid}, 32'd1);
            chk("t4_data", resp_data, 32'h00007F80);
            chk("t4_tag", {27'b0, resp_tag}, 32'd9);
            @(negedge clock);
        end
        chk("t4_load_pulses", ld_n - snap_l, 1);
        resp_ready = 1'b1;
        @(negedge clock);
        chk("t4_released", {31'b0, resp_valid}, 32'd0);

        // illegal ops are swallowed with a single flag pulse
        snap_w = wr_n;
        snap_l = ld_n;
        snap_r = resp_cnt;
        issue(1'b0, 3'b011, 32'h1000, 32'h0, 5'd4, w);
        chk("t5_load_illegal", {31'b0, illegal_op}, 32'd1);
        @(negedge clock);
        chk("t5_load_illegal_drop", {31'b0, illegal_op}, 32'd0);
        issue(1'b1, 3'b100, 32'h4000, 32'h55, 5'd0, w);
        chk("t5_store_illegal", {31'b0, illegal_op}, 32'd1);
        @(negedge clock);
        chk("t5_store_illegal_drop", {31'b0, illegal_op}, 32'd0);
        repeat (6) @(negedge clock);
        chk("t5_no_write", wr_n - snap_w, 0);
        chk("t5_no_load", ld_n - snap_l, 0);
        chk("t5_no_resp", resp_cnt - snap_r, 0);

        // reset while a load waits and stores are buffered
        issue(1'b0, 3'b010, 32'h1000, 32'h0, 5'd3, w);
        issue(1'b1, 3'b010, 32'h5000, 32'hAAAA0000, 5'd0, w);
        issue(1'b1, 3'b010, 32'h5004, 32'hAAAA0001, 5'd0, w);
        chk("t6_in_wait", {30'b0, mem_load_req, resp_valid}, 32'd0);
        rst_n = 1'b0;
        @(negedge clock);
        chk("t6_rst_ctrl", {27'b0, req_ready, mem_load_req, mem_write_req, resp_valid, illegal_op}, 32'd0);
        chk("t6_rst_load_addr", mem_load_addr, 32'd0);
        chk("t6_rst_write_addr", mem_write_addr, 32'd0);
        chk("t6_rst_write_data", mem_write_data, 32'd0);
        chk("t6_rst_write_type", {29'b0, mem_write_type}, 32'd0);
        chk("t6_rst_resp_data", resp_data, 32'd0);
        chk("t6_rst_resp_tag", {27'b0, resp_tag}, 32'd0);
        snap_w = wr_n;
        snap_l = ld_n;
        snap_r = resp_cnt;
        rst_n = 1'b1;
        repeat (10) @(negedge clock);
        chk("t6_no_write", wr_n - snap_w, 0);
        chk("t6_no_load", ld_n - snap_l, 0);
        chk("t6_no_resp", resp_cnt - snap_r, 0);
        req_is_store = 1'b0;
        #1;
        chk("t6_load_ready", {31'b0, req_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
